// File: rtl/revertable_clock_top.sv
// Reversible 4-digit BCD clock: prescaled up/down counter shown on a multiplexed 7-segment display.
// Optional leading-zero blanking on digits 3..1 is enabled by defining REVERT_CLOCK_LZ_BLANK_EN.
module revertable_clock_top #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic       CLK_50,
    input  logic       nCLR,
    input  logic       revert,
    output logic [3:0] SEL,
    output logic [6:0] SEG
);

    localparam int NUM_DIGITS = 4;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // ------------------------------------------------------------------
    // Direction synchronizer
    // ------------------------------------------------------------------
    logic rev_meta;
    logic rev_sync;

    always_ff @(posedge CLK_50 or negedge nCLR) begin
        if (!nCLR) begin
            rev_meta <= 1'b0;
            rev_sync <= 1'b0;
        end else begin
            rev_meta <= revert;
            rev_sync <= rev_meta;
        end
    end

    // ------------------------------------------------------------------
    // Count prescaler
    // ------------------------------------------------------------------
    logic [TW-1:0] presc;
    logic          tick;

    assign tick = (presc == TW'(TICK_DIV - 1));

    always_ff @(posedge CLK_50 or negedge nCLR) begin
        if (!nCLR)     presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // ------------------------------------------------------------------
    // BCD digit chain
    // ------------------------------------------------------------------
    logic [3:0]            digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] step;

    // A digit steps when every lower digit rolls over on this tick.
    assign step[0] = tick;

    genvar g;
    generate
        for (g = 1; g < NUM_DIGITS; g++) begin : g_step
            assign step[g] = step[g-1] &&
                             (rev_sync ? (digit[g-1] == 4'd0) : (digit[g-1] >= 4'd9));
        end

        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            always_ff @(posedge CLK_50 or negedge nCLR) begin
                if (!nCLR) begin
                    digit[g] <= 4'd0;
                end else if (step[g]) begin
                    if (rev_sync)
                        digit[g] <= (digit[g] == 4'd0 || digit[g] > 4'd9) ? 4'd9 : digit[g] - 4'd1;
                    else
                        digit[g] <= (digit[g] >= 4'd9) ? 4'd0 : digit[g] + 4'd1;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [SW-1:0] scan_cnt;
    logic          scan_wrap;
    logic [1:0]    scan_idx;

    assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

    always_ff @(posedge CLK_50 or negedge nCLR) begin
        if (!nCLR) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        case (v)
            4'd0:    seg_encode = 7'h40;
            4'd1:    seg_encode = 7'h79;
            4'd2:    seg_encode = 7'h24;
            4'd3:    seg_encode = 7'h30;
            4'd4:    seg_encode = 7'h19;
            4'd5:    seg_encode = 7'h12;
            4'd6:    seg_encode = 7'h02;
            4'd7:    seg_encode = 7'h78;
            4'd8:    seg_encode = 7'h00;
            4'd9:    seg_encode = 7'h10;
            default: seg_encode = 7'h7F;
        endcase
    endfunction

    logic [NUM_DIGITS-1:0] blank;

    always_comb begin
        blank = '0;
`ifdef REVERT_CLOCK_LZ_BLANK_EN
        // A digit is blank only if it and everything above it is zero; units never blank.
        blank[3] = (digit[3] == 4'd0);
        blank[2] = blank[3] && (digit[2] == 4'd0);
        blank[1] = blank[2] && (digit[1] == 4'd0);
`endif
    end

    always_ff @(posedge CLK_50 or negedge nCLR) begin
        if (!nCLR) begin
            SEL <= 4'b1110;
            SEG <= 7'h40;
        end else begin
            SEL <= ~(4'b0001 << scan_idx);
            SEG <= blank[scan_idx] ? 7'h7F : seg_encode(digit[scan_idx]);
        end
    end

endmodule

// File: tb/tb_revertable_clock_top.sv
// Randomized bench for revertable_clock_top: integer-count reference model plus literal pins.
module tb_revertable_clock_top;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic       CLK_50 = 1'b0;
    logic       nCLR;
    logic       revert;
    logic [3:0] SEL;
    logic [6:0] SEG;

    int checks   = 0;
    int failures = 0;

    revertable_clock_top #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .CLK_50 (CLK_50),
        .nCLR   (nCLR),
        .revert (revert),
        .SEL    (SEL),
        .SEG    (SEG)
    );

    always #10 CLK_50 = ~CLK_50;

    // Reference model: count as a plain integer, edges counted since release.
    int         m_edges;
    int         m_count;
    logic       m_s1, m_s2;
    logic [3:0] exp_sel;
    logic [6:0] exp_seg;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; 9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int idx_at(input int e);
        return (e / SCAN_DIV) % 4;
    endfunction

    function automatic logic [6:0] expect_seg(input int count, input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
`ifdef REVERT_CLOCK_LZ_BLANK_EN
        if (k > 0 && count < p) return 7'h7F;
`endif
        return seg_of((count / p) % 10);
    endfunction

    always @(posedge CLK_50 or negedge nCLR) begin
        if (!nCLR) begin
            m_edges <= 0;
            m_count <= 0;
            m_s1    <= 1'b0;
            m_s2    <= 1'b0;
            exp_sel <= 4'b1110;
            exp_seg <= 7'h40;
        end else begin
            exp_sel <= ~(4'b0001 << idx_at(m_edges));
            exp_seg <= expect_seg(m_count, idx_at(m_edges));
            if (m_edges % TICK_DIV == TICK_DIV - 1)
                m_count <= m_s2 ? (m_count + 9999) % 10000 : (m_count + 1) % 10000;
            m_s1    <= revert;
            m_s2    <= m_s1;
            m_edges <= m_edges + 1;
        end
    end

    task automatic pin(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_edge(input int target);
        int guard = 0;
        while (m_edges < target && guard < 20000) begin
            @(negedge CLK_50);
            guard++;
        end
        if (m_edges < target) begin
            checks++;
            failures++;
            $display("FAIL wait_edge timeout: edges=%0d target=%0d", m_edges, target);
        end
    endtask

    initial begin
        nCLR   = 1'b0;
        revert = 1'b0;
        repeat (3) @(negedge CLK_50);

        fork
            forever begin
                @(negedge CLK_50);
                checks++;
                if (SEL !== exp_sel || SEG !== exp_seg) begin
                    failures++;
                    $display("FAIL scan_out t=%0t: SEL=%b SEG=%h, expected SEL=%b SEG=%h",
                             $time, SEL, SEG, exp_sel, exp_seg);
                end
            end
        join_none

        // Reset-state literals
        pin("reset_sel", int'(SEL), 4'b1110);
        pin("reset_seg", int'(SEG), 7'h40);

        // Up count, then direction toggle at 0005
        #3 nCLR = 1'b1;
        wait_edge(3);  pin("before_first_tick", m_count, 0);
        wait_edge(4);  pin("first_tick", m_count, 1);
        wait_edge(20); pin("up_at_5", m_count, 5);
        revert = 1'b1;
        wait_edge(23); pin("no_glitch_step", m_count, 5);
        wait_edge(24); pin("toggle_down", m_count, 4);

        // Asynchronous reset mid-run
        wait_edge(26);
        #5 nCLR = 1'b0;
        #1 pin("midrun_reset_sel", int'(SEL), 4'b1110);
        pin("midrun_reset_seg", int'(SEG), 7'h40);
        #100 pin("held_reset_sel", int'(SEL), 4'b1110);
        pin("held_reset_seg", int'(SEG), 7'h40);

        // Long up run: carries through every digit, then down across 1000 -> 0999
        @(negedge CLK_50);
        revert = 1'b0;
        #3 nCLR = 1'b1;
        wait_edge(40);  pin("carry_0009_0010", m_count, 10);
        wait_edge(169); pin("c42_units_sel", int'(SEL), 4'b1110);
        pin("c42_units_seg", int'(SEG), 7'h24);
        wait_edge(171); pin("c42_tens_sel", int'(SEL), 4'b1101);
        pin("c42_tens_seg", int'(SEG), 7'h19);
        wait_edge(173); pin("c43_hund_sel", int'(SEL), 4'b1011);
`ifdef REVERT_CLOCK_LZ_BLANK_EN
        pin("c43_hund_seg", int'(SEG), 7'h7F);
`else
        pin("c43_hund_seg", int'(SEG), 7'h40);
`endif
        wait_edge(400);  pin("carry_0099_0100", m_count, 100);
        wait_edge(4000); pin("carry_0999_1000", m_count, 1000);
        wait_edge(4937); pin("c1234_units_sel", int'(SEL), 4'b1110);
        pin("c1234_units_seg", int'(SEG), 7'h19);
        wait_edge(4939); pin("c1234_tens_sel", int'(SEL), 4'b1101);
        pin("c1234_tens_seg", int'(SEG), 7'h30);
        wait_edge(4940); pin("up_at_1235", m_count, 1235);
        revert = 1'b1;
        wait_edge(5880); pin("down_at_1000", m_count, 1000);
        wait_edge(5884); pin("borrow_1000_0999", m_count, 999);

        // Down from reset: 0000 -> 9999, then back up across 9999 -> 0000
        @(negedge CLK_50);
        #3 nCLR = 1'b0;
        revert = 1'b1;
        #100;
        @(negedge CLK_50);
        #3 nCLR = 1'b1;
        wait_edge(4);  pin("wrap_down_9999", m_count, 9999);
        wait_edge(8);  pin("down_9998", m_count, 9998);
        revert = 1'b0;
        wait_edge(12); pin("up_9999", m_count, 9999);
        wait_edge(16); pin("wrap_up_0000", m_count, 0);
        wait_edge(19); pin("zero_tens_sel", int'(SEL), 4'b1101);
`ifdef REVERT_CLOCK_LZ_BLANK_EN
        pin("zero_tens_seg", int'(SEG), 7'h7F);
`else
        pin("zero_tens_seg", int'(SEG), 7'h40);
`endif

        // Random direction changes, checked cycle by cycle against the model
        for (int i = 0; i < 2500; i++) begin
            @(negedge CLK_50);
            if ($urandom_range(0, 11) == 0) revert = ~revert;
            if (i == 1200) begin
                #3 nCLR = 1'b0;
                #7 nCLR = 1'b1;
            end
        end

        @(negedge CLK_50);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
